// File: rtl/pooling_pkg.sv
// Shared helpers for the streaming max-pool block.
//   MAX_W    : widest lane the compare helper handles; lanes are extended to it.
//   cw()     : counter width for a range 0..n-1, never narrower than one bit.
//   lane_gt(): per-lane "candidate strictly beats current" test. Ties return 0,
//              so the caller keeps the value it already holds.
package pooling_pkg;

  localparam int MAX_W = 64;

  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic lane_gt(input logic [MAX_W-1:0] cur,
                                   input logic [MAX_W-1:0] cand,
                                   input logic             is_signed);
    if (is_signed) begin
      return $signed(cand) > $signed(cur);
    end
    return cand > cur;
  endfunction

endpackage

// File: rtl/maxpool_stream_if.sv
// Stream bundle for maxpool_stream.
//   in_valid/in_ready/in_data            : pixel stream into the pooler
//   out_valid/out_ready/out_data/out_last: pooled pixel stream out
// master = the side that feeds pixels and consumes results; slave = pooler.
interface maxpool_stream_if #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [CHANNELS*DATA_W-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [CHANNELS*DATA_W-1:0] out_data;
  logic                       out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pool_max_lane.sv
// One channel lane of the pooler: 2-input compare-select.
//   cur     : value already held (wins ties)
//   cand    : incoming value, selected only when strictly greater
//   max_val : selected value, DATA_W bits (no width growth)
// SIGNED != 0 compares as two's complement, otherwise unsigned.
module pool_max_lane
  import pooling_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SIGNED = 1
) (
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] cand,
  output logic [DATA_W-1:0] max_val
);

  if (DATA_W > MAX_W) begin : g_width_chk
    $error("pool_max_lane: DATA_W exceeds MAX_W");
  end

  logic [MAX_W-1:0] cur_ext;
  logic [MAX_W-1:0] cand_ext;

  // Extend to the helper width so the compare sees the lane's true sign.
  if (SIGNED != 0) begin : g_signed
    assign cur_ext  = MAX_W'($signed(cur));
    assign cand_ext = MAX_W'($signed(cand));
  end else begin : g_unsigned
    assign cur_ext  = MAX_W'(cur);
    assign cand_ext = MAX_W'(cand);
  end

  assign max_val = lane_gt(cur_ext, cand_ext, SIGNED != 0) ? cand : cur;

endmodule

// File: rtl/maxpool_stream.sv
// Streaming POOL_K x POOL_K, stride POOL_K max-pooling unit.
// Pixels arrive in raster order, all channels per beat; one pooled pixel
// leaves per completed window, one cycle after its last pixel is accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of maxpool_stream_if (in_* pixels, out_* results)
// Horizontal maxima of a window row go through hacc; per-window partial
// results of earlier window rows live in a row buffer indexed by ox.
module maxpool_stream
  import pooling_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 4,
  parameter int POOL_K   = 2,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int SIGNED   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  maxpool_stream_if.slave bus
);

  localparam int OUT_W = IMG_W / POOL_K;
  localparam int OUT_H = IMG_H / POOL_K;
  localparam int LW    = CHANNELS * DATA_W;
  localparam int KW    = cw(POOL_K);
  localparam int OXW   = cw(OUT_W);
  localparam int OYW   = cw(OUT_H);

  if (POOL_K < 2) begin : g_k_chk
    $error("maxpool_stream: POOL_K must be at least 2");
  end
  if (IMG_W % POOL_K != 0) begin : g_w_chk
    $error("maxpool_stream: IMG_W must be divisible by POOL_K");
  end
  if (IMG_H % POOL_K != 0) begin : g_h_chk
    $error("maxpool_stream: IMG_H must be divisible by POOL_K");
  end

  logic [KW-1:0]  kx_reg, kx_next;
  logic [OXW-1:0] ox_reg, ox_next;
  logic [KW-1:0]  ky_reg, ky_next;
  logic [OYW-1:0] oy_reg, oy_next;

  logic [LW-1:0] hacc_reg;
  logic [LW-1:0] rowbuf [OUT_W];
  logic [LW-1:0] rowbuf_rd;
  logic [LW-1:0] h_data;   // max(hacc, pixel): row maximum once kx is last
  logic [LW-1:0] v_data;   // max(rowbuf[ox], h): window maximum so far

  logic          out_valid_reg;
  logic [LW-1:0] out_data_reg;
  logic          out_last_reg;

  logic accept;
  logic kx_last, ox_last, ky_last, oy_last;

  // No skid buffer: a pending result blocks input until it is taken.
  assign bus.in_ready  = !out_valid_reg || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;

  assign kx_last = (kx_reg == KW'(POOL_K - 1));
  assign ox_last = (ox_reg == OXW'(OUT_W - 1));
  assign ky_last = (ky_reg == KW'(POOL_K - 1));
  assign oy_last = (oy_reg == OYW'(OUT_H - 1));

  assign rowbuf_rd = rowbuf[ox_reg];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      pool_max_lane #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
      ) u_hmax (
        .cur     (hacc_reg[gi*DATA_W +: DATA_W]),
        .cand    (bus.in_data[gi*DATA_W +: DATA_W]),
        .max_val (h_data[gi*DATA_W +: DATA_W])
      );

      pool_max_lane #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
      ) u_vmax (
        .cur     (rowbuf_rd[gi*DATA_W +: DATA_W]),
        .cand    (h_data[gi*DATA_W +: DATA_W]),
        .max_val (v_data[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // Raster position, wrapping kx -> ox -> ky -> oy; a full wrap starts the
  // next frame with no dead cycle.
  always_comb begin
    kx_next = kx_reg;
    ox_next = ox_reg;
    ky_next = ky_reg;
    oy_next = oy_reg;
    if (accept) begin
      if (kx_last) begin
        kx_next = '0;
        if (ox_last) begin
          ox_next = '0;
          if (ky_last) begin
            ky_next = '0;
            oy_next = oy_last ? '0 : oy_reg + OYW'(1);
          end else begin
            ky_next = ky_reg + KW'(1);
          end
        end else begin
          ox_next = ox_reg + OXW'(1);
        end
      end else begin
        kx_next = kx_reg + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx_reg   <= '0;
      ox_reg   <= '0;
      ky_reg   <= '0;
      oy_reg   <= '0;
      hacc_reg <= '0;
    end else begin
      kx_reg <= kx_next;
      ox_reg <= ox_next;
      ky_reg <= ky_next;
      oy_reg <= oy_next;
      if (accept) begin
        hacc_reg <= (kx_reg == '0) ? bus.in_data : h_data;
      end
    end
  end

  // Row buffer needs no reset: the first window row always overwrites it.
  always_ff @(posedge clk) begin
    if (accept && kx_last && !ky_last) begin
      rowbuf[ox_reg] <= (ky_reg == '0) ? h_data : v_data;
    end
  end

  // Output register: a new result may load in the same cycle the old one
  // is handed off; otherwise a handshake simply empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (accept && kx_last && ky_last) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= v_data;
      out_last_reg  <= ox_last && oy_last;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: a 4x4, 2-channel unsigned instance driven with
// ramp frames (plain, backpressure, bubbles, reset mid-frame, back-to-back)
// and two 2x2 single-lane instances (signed / unsigned) for compare polarity.
module tb_maxpool_stream;

  logic clk;
  logic rst_n;

  maxpool_stream_if #(.DATA_W(8), .CHANNELS(2)) bus ();
  maxpool_stream_if #(.DATA_W(8), .CHANNELS(1)) sbus_s ();
  maxpool_stream_if #(.DATA_W(8), .CHANNELS(1)) sbus_u ();

  maxpool_stream #(
    .DATA_W(8), .CHANNELS(2), .POOL_K(2), .IMG_W(4), .IMG_H(4), .SIGNED(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  maxpool_stream #(
    .DATA_W(8), .CHANNELS(1), .POOL_K(2), .IMG_W(2), .IMG_H(2), .SIGNED(1)
  ) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus_s)
  );

  maxpool_stream #(
    .DATA_W(8), .CHANNELS(1), .POOL_K(2), .IMG_W(2), .IMG_H(2), .SIGNED(0)
  ) dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus_u)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_push = 0;
  int pos_cnt = 0;
  int acc_cnt = 0;
  bit bp_arm = 0;

  // Hand-computed ramp window results (ch1 in the high byte, ch0 low).
  logic [15:0] exp_win [4] = '{16'h0F05, 16'h0D07, 16'h070D, 16'h050F};

  always @(posedge clk) pos_cnt <= pos_cnt + 1;
  always @(posedge clk) if (bus.in_valid && bus.in_ready) acc_cnt <= acc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Index into exp_win for the raster pixel that closes a window, else -1.
  function automatic int win_of(input int i);
    case (i)
      5:  return 0;
      7:  return 1;
      13: return 2;
      15: return 3;
      default: return -1;
    endcase
  endfunction

  // Called at negedge+1; returns at negedge+1 after the pixel was taken.
  task automatic send_ramp(input int i, input bit push, input bit bubbles);
    int guard;
    int w;
    guard = 0;
    if (bubbles) begin
      while ($urandom_range(0, 9) < 4) begin
        bus.in_valid = 1'b0;
        @(negedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = {8'(15 - i), 8'(i)};
    while (!bus.in_ready) begin
      if (guard == 200) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout pixel %0d got 0 want 1", i);
        bus.in_valid = 1'b0;
        return;
      end
      guard++;
      @(negedge clk); #1;
    end
    w = win_of(i);
    if (push && w >= 0) begin
      sb.push_back('{data: exp_win[w], last: (i == 15), cyc: pos_cnt + 1});
      n_push++;
    end
    @(negedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit push, input bit bubbles);
    for (int i = 0; i < 16; i++) send_ramp(i, push, bubbles);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk); #3;
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
    end
  endtask

  // Monitor: pops and compares on every output handshake; also checks that
  // each fresh result appears exactly one cycle after its window closed.
  initial begin : monitor
    bit fresh;
    fresh = 1'b1;
    forever begin
      @(negedge clk); #2;
      if (rst_n && bus.out_valid) begin
        if (fresh) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got %h want none", bus.out_data);
          end else begin
            chk("latency_cycle", 32'(pos_cnt), 32'(sb[0].cyc));
          end
        end
        if (bus.out_ready) begin
          if (sb.size() != 0) begin
            chk("out_data", 32'(bus.out_data), 32'(sb[0].data));
            chk("out_last", 32'(bus.out_last), 32'(sb[0].last));
            void'(sb.pop_front());
          end
          n_out++;
          fresh = 1'b1;
        end else begin
          fresh = 1'b0;
        end
      end else begin
        fresh = 1'b1;
      end
    end
  end

  // Backpressure: when armed, stall the first result and confirm it holds.
  initial begin : bp_ctl
    int acc0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp_arm && bus.out_valid) begin
        bp_arm = 1'b0;
        bus.out_ready = 1'b0;
        acc0 = acc_cnt;
        repeat (5) begin
          @(negedge clk); #2;
          chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
          chk("bp_out_data", 32'(bus.out_data), 32'h0F05);
          chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
          chk("bp_no_accept", 32'(acc_cnt), 32'(acc0));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    end
  end

  initial begin : stim
    logic [7:0] spix [4];
    spix = '{8'h7F, 8'h80, 8'h01, 8'h00};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    sbus_s.in_valid = 1'b0;
    sbus_s.in_data  = '0;
    sbus_s.out_ready = 1'b1;
    sbus_u.in_valid = 1'b0;
    sbus_u.in_data  = '0;
    sbus_u.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", 32'(bus.out_data), 32'd0);
    chk("reset_out_last", 32'(bus.out_last), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Signed vs unsigned compare on one 2x2 window.
    for (int i = 0; i < 4; i++) begin
      sbus_s.in_valid = 1'b1;
      sbus_u.in_valid = 1'b1;
      sbus_s.in_data  = spix[i];
      sbus_u.in_data  = spix[i];
      @(negedge clk); #1;
    end
    sbus_s.in_valid = 1'b0;
    sbus_u.in_valid = 1'b0;
    #1;
    chk("signed_valid", 32'(sbus_s.out_valid), 32'd1);
    chk("signed_data", 32'(sbus_s.out_data), 32'h7F);
    chk("signed_last", 32'(sbus_s.out_last), 32'd1);
    chk("unsigned_valid", 32'(sbus_u.out_valid), 32'd1);
    chk("unsigned_data", 32'(sbus_u.out_data), 32'h80);
    @(negedge clk); #1;

    // Plain ramp.
    send_frame(1'b1, 1'b0);
    drain();
    $display("scenario ramp done outputs %0d", n_out);

    // Backpressure on the first result.
    bp_arm = 1'b1;
    send_frame(1'b1, 1'b0);
    drain();
    $display("scenario backpressure done outputs %0d", n_out);

    // Random input bubbles.
    send_frame(1'b1, 1'b1);
    drain();
    $display("scenario bubbles done outputs %0d", n_out);

    // Reset after six accepted pixels; the sixth closes window 0.
    for (int i = 0; i < 5; i++) send_ramp(i, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = {8'(15 - 5), 8'(5)};
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_out_last", 32'(bus.out_last), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    send_frame(1'b1, 1'b0);
    drain();
    $display("scenario reset_mid_frame done outputs %0d", n_out);

    // Two frames back to back.
    send_frame(1'b1, 1'b0);
    send_frame(1'b1, 1'b0);
    drain();
    $display("scenario back_to_back done outputs %0d", n_out);

    repeat (3) @(negedge clk);
    #3;
    chk("total_outputs", 32'(n_out), 32'(n_push));
    chk("total_outputs_24", 32'(n_out), 32'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- Streaming K×K, stride-K max-pooling unit for CNN feature maps, placed directly after a convolution layer's output stream.
- Generalises the pairwise pooling controller to a parametrised window, image width/height and channel count, with signed/unsigned compare and ready/valid backpressure.
- Consumes one pixel (all channels) per accepted beat in raster order and emits one pooled pixel per completed window.

Parameters:
- DATA_W, 8, bits per channel value.
- CHANNELS, 4, parallel channel lanes per pixel.
- POOL_K, 2, window size and stride (≥2).
- IMG_W, 28, input width in pixels; must be divisible by POOL_K (elaboration-time assertion).
- IMG_H, 28, input height in rows; must be divisible by POOL_K (elaboration-time assertion).
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_data  in  CHANNELS*DATA_W  pixel; lane c occupies bits [c*DATA_W +: DATA_W].
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts the pooled pixel.
- out_data  out  CHANNELS*DATA_W  pooled pixel, same packing as in_data.
- out_last  out  1  qualifies the final pooled pixel of a frame.

Behaviour:
- Reset: asynchronous assert on rst_n low. On reset, out_valid=0, out_data=0, out_last=0, and all counters=0. Row-buffer contents are don't-care, since the first window row always overwrites them.
- Accept: a pixel is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready. There is no skid buffer.
- Counters advance only on accept:
  - kx in 0..K-1.
  - ox in 0..IMG_W/K-1.
  - ky in 0..K-1.
  - oy in 0..IMG_H/K-1.
  - Wrap order: kx → ox → ky → oy.
- Horizontal accumulator hacc (per lane):
  - kx==0: load the pixel.
  - Otherwise: hacc = max(hacc, pixel).
- Row buffer: depth IMG_W/K, width CHANNELS*DATA_W, indexed by ox. On kx==K-1 (using h = max(hacc, pixel)):
  - ky==0: rowbuf[ox] = h.
  - 0<ky<K-1: rowbuf[ox] = max(rowbuf[ox], h).
  - ky==K-1: result = max(rowbuf[ox], h) is written to out_data, and out_valid is set on the next clock edge. Latency is 1 cycle from accepting the window's last pixel.
- out_last is set together with out_valid when oy, ox, ky and kx are all at their maxima. The counters then wrap to 0, so the next frame may follow back-to-back.
- Output hold: out_valid stays high and out_data/out_last stay stable until out_ready. On handshake with no new result, out_valid drops. A new result may load in the same cycle as a handshake.
- Compare: per lane, a strict greater-than selects the new value; ties keep the existing value. SIGNED selects $signed or unsigned comparison. No width growth: result width = DATA_W.
- Bubbles: in_valid gaps freeze all state. Results are independent of gap pattern.
- Reset mid-frame: all partial windows are discarded and the next accepted pixel is treated as frame pixel (0,0).
- Max outputs per frame: (IMG_W/K)*(IMG_H/K).

Decomposition:
- Shared package pooling_pkg holds:
  - the lane max function (takes signed flag);
  - counter-width helper constants (CW = $clog2 of each range).
- Sub-module pool_max_lane: one DATA_W lane, 2-input compare-select with SIGNED parameter. Instantiated per channel for the hacc and row-buffer merges.
- Top level holds the counters, row buffer (inferred RAM/regs) and output register.

Test Plan:
- Ramp (K=2, W=H=4, CH=2, DATA_W=8, SIGNED=0). Stimulus: ch0 = row*4+col, ch1 = 15-(row*4+col), continuous valid, out_ready=1. Expect ch0 {5,7,13,15}, ch1 {15,13,7,5}; out_last only on the 4th output; each output 1 cycle after its window completes.
- Signed compare. Stimulus: one window 0x7F, 0x80, 0x01, 0x00. Expect 0x7F with SIGNED=1 and 0x80 with SIGNED=0.
- Backpressure. Stimulus: ramp, with out_ready held low for 5 cycles after the first output. Expect out_data=5/15 to stay stable, in_ready=0, and no pixel consumed. The remaining outputs must be unchanged.
- Bubbles. Stimulus: ramp with in_valid randomly deasserted about 40% of the time. Expect results identical to the first scenario.
- Reset mid-frame. Stimulus: pulse rst_n low after 6 accepted pixels. Expect out_valid=0 and out_last=0 immediately (asynchronous). A following full ramp frame yields exactly {5,7,13,15}/{15,13,7,5}.
- Back-to-back frames. Stimulus: two ramp frames with no gap. Expect 8 outputs, out_last asserted on the 4th and 8th only.
